// File: rtl/operand_loader.sv
// operand_loader: captures two 4-bit operands from switches using debounced load/clear buttons.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   sw        operand value from switches (held static by the operator)
//   btn_load  load pushbutton, active-high, bouncing
//   btn_clr   clear pushbutton, active-high, bouncing
//   A, B      registered operands for the downstream adder
//   valid     high while A and B hold a completed pair
//   state     FSM state code (00 WAIT_A, 01 WAIT_B, 10 READY)
//   pair_cnt  count of completed pairs, wraps modulo 256
// Build option: define OPERAND_LOADER_DEBOUNCE_EN to enable the debounce counters.
module operand_loader #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_CNT_W  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_load,
  input  logic       btn_clr,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       valid,
  output logic [1:0] state,
  output logic [7:0] pair_cnt
);
  typedef enum logic [1:0] {WAIT_A = 2'b00, WAIT_B = 2'b01, READY = 2'b10} state_t;
  if (DB_CYCLES < 1 || DB_CYCLES >= 2 ** DB_CNT_W) begin : g_bad_db
    $error("DB_CYCLES does not fit in DB_CNT_W bits");
  end
  // Index 0 is load, index 1 is clear.
  logic [1:0] btn, s1, s2, stab, stab_d, pulse;
  state_t st;
  assign btn = {btn_clr, btn_load};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      stab_d <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      stab_d <= stab;
    end
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  // Counter tracks how long the synchronised level has disagreed with the
  // accepted level; any agreement restarts the count, so bounces never toggle.
  logic [DB_CNT_W-1:0] cnt [2];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stab <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else
      for (int i = 0; i < 2; i++)
        if (s2[i] == stab[i]) cnt[i] <= '0;
        else if (cnt[i] == DB_CNT_W'(DB_CYCLES - 1)) begin
          cnt[i] <= '0;
          stab[i] <= ~stab[i];
        end else cnt[i] <= cnt[i] + 1'b1;
`else
  always_ff @(posedge clk or negedge rst)
    if (!rst) stab <= '0;
    else stab <= s2;
`endif
  assign pulse = stab & ~stab_d;
  assign state = st;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= WAIT_A;
      A <= '0;
      B <= '0;
      valid <= 1'b0;
      pair_cnt <= '0;
    end else if (pulse[1]) begin
      st <= WAIT_A;
      A <= '0;
      B <= '0;
      valid <= 1'b0;
    end else if (st != WAIT_A && st != WAIT_B && st != READY) st <= WAIT_A;
    else if (pulse[0])
      case (st)
        WAIT_A: begin
          A <= sw;
          st <= WAIT_B;
        end
        WAIT_B: begin
          B <= sw;
          valid <= 1'b1;
          pair_cnt <= pair_cnt + 8'd1;
          st <= READY;
        end
        default: begin
          A <= sw;
          B <= '0;
          valid <= 1'b0;
          st <= WAIT_B;
        end
      endcase
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed self-checking bench for operand_loader with DB_CYCLES=4.
module tb_operand_loader;
  localparam int DB = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int LAT = DB + 2;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] sw = '0;
  logic btn_load = 1'b0;
  logic btn_clr = 1'b0;
  logic [3:0] A, B;
  logic valid;
  logic [1:0] state;
  logic [7:0] pair_cnt;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_cnt = '0;
  operand_loader #(.DB_CYCLES(DB), .DB_CNT_W(3)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_load(btn_load), .btn_clr(btn_clr),
    .A(A), .B(B), .valid(valid), .state(state), .pair_cnt(pair_cnt)
  );
  always #5 clk = ~clk;
  task automatic press(input logic [3:0] v, input logic ld, input logic cl);
    @(negedge clk);
    sw = v;
    btn_load = ld;
    btn_clr = cl;
    repeat (LAT + 2) @(negedge clk);
    btn_load = 1'b0;
    btn_clr = 1'b0;
    repeat (LAT + 4) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_cnt = '0;
  endtask
  task automatic test_reset();
    #3;
    checks++; if (A !== 4'h0) begin errors++; $display("FAIL reset_A got %h want 0", A); end
    checks++; if (B !== 4'h0) begin errors++; $display("FAIL reset_B got %h want 0", B); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b want 00", state); end
    checks++; if (pair_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", pair_cnt); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_load_pair();
    press(4'h9, 1'b1, 1'b0);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL pair_stateB got %b want 01", state); end
    checks++; if (A !== 4'h9) begin errors++; $display("FAIL pair_A1 got %h want 9", A); end
    press(4'h6, 1'b1, 1'b0);
    exp_cnt++;
    checks++; if (A !== 4'h9) begin errors++; $display("FAIL pair_A got %h want 9", A); end
    checks++; if (B !== 4'h6) begin errors++; $display("FAIL pair_B got %h want 6", B); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL pair_valid got %b want 1", valid); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL pair_state got %b want 10", state); end
    checks++; if (pair_cnt !== exp_cnt) begin errors++; $display("FAIL pair_cnt got %0d want %0d", pair_cnt, exp_cnt); end
  endtask
  task automatic test_reload_timing();
    @(negedge clk);
    sw = 4'h3;
    btn_load = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    checks++; if (A !== 4'h9) begin errors++; $display("FAIL early_A got %h want 9", A); end
    @(posedge clk);
    #1;
    checks++; if (A !== 4'h3) begin errors++; $display("FAIL reload_A got %h want 3", A); end
    checks++; if (B !== 4'h0) begin errors++; $display("FAIL reload_B got %h want 0", B); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reload_valid got %b want 0", valid); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL reload_state got %b want 01", state); end
    repeat (LAT + 2) @(negedge clk);
    btn_load = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    checks++; if (pair_cnt !== exp_cnt) begin errors++; $display("FAIL reload_cnt got %0d want %0d", pair_cnt, exp_cnt); end
    checks++; if (A !== 4'h3) begin errors++; $display("FAIL held_A got %h want 3", A); end
  endtask
  task automatic test_clear_priority();
    press(4'h5, 1'b1, 1'b1);
    checks++; if (A !== 4'h0) begin errors++; $display("FAIL clrpri_A got %h want 0", A); end
    checks++; if (B !== 4'h0) begin errors++; $display("FAIL clrpri_B got %h want 0", B); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL clrpri_state got %b want 00", state); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL clrpri_valid got %b want 0", valid); end
    checks++; if (pair_cnt !== exp_cnt) begin errors++; $display("FAIL clrpri_cnt got %0d want %0d", pair_cnt, exp_cnt); end
  endtask
  task automatic test_bounce();
    @(negedge clk);
    sw = 4'h9;
    for (int i = 0; i < 6; i++) begin
      btn_load = ~btn_load;
      repeat (2) @(negedge clk);
    end
    btn_load = 1'b1;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    repeat (LAT) @(posedge clk);
    #1;
    checks++; if (A !== 4'h0) begin errors++; $display("FAIL bounce_early_A got %h want 0", A); end
    @(posedge clk);
    #1;
    checks++; if (A !== 4'h9) begin errors++; $display("FAIL bounce_A got %h want 9", A); end
    repeat (LAT + 2) @(negedge clk);
    btn_load = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL bounce_state got %b want 01", state); end
    checks++; if (B !== 4'h0) begin errors++; $display("FAIL bounce_B got %h want 0", B); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL bounce_valid got %b want 0", valid); end
`else
    repeat (LAT + 2) @(negedge clk);
    btn_load = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    exp_cnt = exp_cnt + 8'd2;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL bounce_state got %b want 10", state); end
    checks++; if (B !== 4'h9) begin errors++; $display("FAIL bounce_B got %h want 9", B); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL bounce_valid got %b want 1", valid); end
`endif
    checks++; if (pair_cnt !== exp_cnt) begin errors++; $display("FAIL bounce_cnt got %0d want %0d", pair_cnt, exp_cnt); end
    press(4'h0, 1'b0, 1'b1);
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 512; i++) begin
      press(4'(i), 1'b1, 1'b0);
      if (i == 509) begin
        checks++; if (pair_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", pair_cnt); end
      end
    end
    checks++; if (pair_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt got %0d want 0", pair_cnt); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", valid); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL wrap_state got %b want 10", state); end
    checks++; if (A !== 4'hE) begin errors++; $display("FAIL wrap_A got %h want e", A); end
    checks++; if (B !== 4'hF) begin errors++; $display("FAIL wrap_B got %h want f", B); end
  endtask
  task automatic test_reset_mid();
    press(4'h2, 1'b1, 1'b0);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL mid_pre_state got %b want 01", state); end
    @(negedge clk);
    btn_load = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (A !== 4'h0) begin errors++; $display("FAIL mid_A got %h want 0", A); end
    checks++; if (B !== 4'h0) begin errors++; $display("FAIL mid_B got %h want 0", B); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", valid); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL mid_state got %b want 00", state); end
    checks++; if (pair_cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", pair_cnt); end
    btn_load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL mid_idle_state got %b want 00", state); end
    press(4'h7, 1'b1, 1'b0);
    checks++; if (A !== 4'h7) begin errors++; $display("FAIL mid_next_A got %h want 7", A); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL mid_next_state got %b want 01", state); end
  endtask
  initial begin
    test_reset();
    test_load_pair();
    test_reload_timing();
    test_clear_priority();
    test_bounce();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000, meaning the number of consecutive stable clk cycles required to accept a button level (10 ms at 100 MHz).
REQ-002 SHALL have parameter DB_CNT_W, default 20, meaning the debounce counter width; DB_CYCLES SHALL fit in DB_CNT_W bits.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sw  input  4  operand value from the board switches (asynchronous).
REQ-006 SHALL have port btn_load  input  1  load pushbutton, active-high, asynchronous, bouncing.
REQ-007 SHALL have port btn_clr  input  1  clear pushbutton, active-high, asynchronous, bouncing.
REQ-008 SHALL have port A  output  4  registered operand A, driven to the downstream 4-bit adder.
REQ-009 SHALL have port B  output  4  registered operand B, driven to the downstream 4-bit adder.
REQ-010 SHALL have port valid  output  1  high while both A and B hold a completed operand pair.
REQ-011 SHALL have port state  output  2  current FSM state code, for the display driver.
REQ-012 SHALL have port pair_cnt  output  8  count of completed operand pairs.

Function
REQ-013 SHALL pass each button through a 2-flip-flop synchroniser before any other logic.
REQ-014 SHALL debounce each synchronised button independently: the counter clears whenever the synchronised level equals the stable level, and otherwise increments; the stable level toggles on the cycle the counter equals DB_CYCLES-1.
REQ-015 SHALL generate a single-cycle press pulse on each 0->1 transition of a stable level; a clean held press yields its pulse 2+DB_CYCLES cycles after the input edge.
REQ-016 SHALL implement the FSM states WAIT_A=2'b00, WAIT_B=2'b01 and READY=2'b10; code 2'b11 SHALL transition to WAIT_A.
REQ-017 On a load pulse in WAIT_A: A<=sw and the FSM moves to WAIT_B.
REQ-018 On a load pulse in WAIT_B: B<=sw, valid<=1, pair_cnt<=pair_cnt+1, and the FSM moves to READY.
REQ-019 On a load pulse in READY: A<=sw, B<=0, valid<=0, and the FSM moves to WAIT_B.
REQ-020 On a clear pulse in any state: A<=0, B<=0, valid<=0, and the FSM moves to WAIT_A; pair_cnt is unchanged.
REQ-021 SHALL give a clear pulse priority over a load pulse in the same cycle.
REQ-022 SHALL capture sw on the pulse cycle, with outputs visible one cycle after the pulse; sw SHALL be sampled unsynchronised, since the operator holds it static.
REQ-023 SHALL wrap pair_cnt modulo 256 (255 -> 0).
REQ-024 SHALL register all outputs; there SHALL be no combinational path from inputs to outputs.
REQ-025 SHALL generate no pulse when a button is held: only one pulse per stable press.

Reset
REQ-026 rst low SHALL immediately force A=0, B=0, valid=0, state=WAIT_A, pair_cnt=0, clear the synchronisers, debounce counters and stable levels, and suppress any pending pulses.
REQ-027 A reset asserted mid-debounce or mid-sequence SHALL discard the partial operand; operation resumes from WAIT_A on the first clk edge after rst rises.

Configuration
REQ-028 The macro OPERAND_LOADER_DEBOUNCE_EN SHALL control debouncing: when defined, REQ-014 applies; when undefined, the debounce counters are omitted, the stable level equals the synchronised level, and a pulse arrives 3 cycles after a clean input edge (every bounce edge pulses).

Verification
REQ-029 Scenario: with DB_CYCLES=4, reset, then press load with sw=4'h9 and later press load with sw=4'h6 -> A=9, B=6, valid=1, state=2'b10, pair_cnt=1.
REQ-030 Scenario: from READY, press load with sw=4'h3 -> A=3, B=0, valid=0, state=2'b01, pair_cnt unchanged.
REQ-031 Scenario: with DEBOUNCE_EN and DB_CYCLES=4, toggle btn_load every 2 cycles 6 times, then hold high -> exactly one pulse, and A updates only after 4 stable cycles.
REQ-032 Scenario: load and clear pulses land in the same cycle while in WAIT_B -> A=0, B=0, state=WAIT_A, pair_cnt unchanged.
REQ-033 Scenario: complete 256 operand pairs -> pair_cnt wraps to 0 and valid=1.
REQ-034 Scenario: assert rst while in WAIT_B with the debounce counter nonzero -> all outputs are 0 and state=WAIT_A within the same cycle; the next press loads A.
